// File: rtl/wb_pkg.sv
// Shared Wishbone widths and arbiter state encoding, reused by the interconnect blocks.
package wb_pkg;
    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
endpackage

// File: rtl/wb_rr_pick.sv
// Round-robin pick: rotate requests to start after 'last', take the lowest set bit, un-rotate.
module wb_rr_pick #(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic [$clog2(NUM_MASTERS)-1:0] last,
    output logic                           valid,
    output logic [$clog2(NUM_MASTERS)-1:0] idx
);
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int SUM_W = IDX_W + 1;
    localparam logic [SUM_W-1:0] N_S = SUM_W'(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] rot;
    logic [IDX_W-1:0]       off;
    logic [SUM_W-1:0]       sum;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_rot
            logic [SUM_W-1:0] src;
            logic [IDX_W-1:0] src_idx;
            assign src     = SUM_W'(gi) + {1'b0, last} + SUM_W'(1);
            assign src_idx = IDX_W'((src >= N_S) ? (src - N_S) : src);
            assign rot[gi] = req[src_idx];
        end
    endgenerate

    // Scan downward so the lowest set bit is the one left standing.
    always_comb begin
        off = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
    end

    assign valid = |req;
    assign sum   = {1'b0, off} + {1'b0, last} + SUM_W'(1);
    assign idx   = IDX_W'((sum >= N_S) ? (sum - N_S) : sum);
endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter: one granted master per CYC, ACK routing and STB timeout.
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [NUM_MASTERS*WB_ADR_W-1:0] m_adr_i,
    input  logic [NUM_MASTERS*WB_SEL_W-1:0] m_sel_i,
    input  logic [NUM_MASTERS*WB_DAT_W-1:0] m_dat_i,
    output logic [WB_DAT_W-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [WB_ADR_W-1:0]             s_adr_o,
    output logic [WB_SEL_W-1:0]             s_sel_o,
    output logic [WB_DAT_W-1:0]             s_dat_o,
    input  logic [WB_DAT_W-1:0]             s_dat_i,
    input  logic                            s_ack_i
);
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int TMO_W = $clog2(TIMEOUT);

    logic [0:0]       state_reg, state_next;
    logic [IDX_W-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0] last_reg, last_next;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;

    logic [WB_ADR_W-1:0] adr_arr [NUM_MASTERS];
    logic [WB_SEL_W-1:0] sel_arr [NUM_MASTERS];
    logic [WB_DAT_W-1:0] dat_arr [NUM_MASTERS];

    logic             busy, cyc_g, tmo_hit, pick_valid;
    logic [IDX_W-1:0] pick_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
            assign adr_arr[gi] = m_adr_i[gi*WB_ADR_W +: WB_ADR_W];
            assign sel_arr[gi] = m_sel_i[gi*WB_SEL_W +: WB_SEL_W];
            assign dat_arr[gi] = m_dat_i[gi*WB_DAT_W +: WB_DAT_W];
        end
    endgenerate

    wb_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
        .req   (m_cyc_i),
        .last  (last_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign busy    = (state_reg == ST_BUSY);
    assign cyc_g   = m_cyc_i[grant_reg];
    assign tmo_hit = (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));
    assign m_dat_o = s_dat_i;

    // Slave side is a combinational copy of the granted master, zeroed when idle.
    always_comb begin
        s_cyc_o = busy & cyc_g;
        s_stb_o = busy & cyc_g & m_stb_i[grant_reg];
        s_we_o  = busy & m_we_i[grant_reg];
        s_adr_o = busy ? adr_arr[grant_reg] : '0;
        s_sel_o = busy ? sel_arr[grant_reg] : '0;
        s_dat_o = busy ? dat_arr[grant_reg] : '0;
    end

    // A same-cycle ack beats the timeout.
    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        if (s_stb_o) begin
            m_ack_o[grant_reg] = s_ack_i;
            m_err_o[grant_reg] = ~s_ack_i & tmo_hit;
        end
    end

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        last_next    = last_reg;
        tmo_cnt_next = '0;
        if (!busy) begin
            if (pick_valid) begin
                state_next = ST_BUSY;
                grant_next = pick_idx;
            end
        end else if (!cyc_g) begin
            state_next = ST_IDLE;
            last_next  = grant_reg;
        end else if (s_stb_o && !s_ack_i && !tmo_hit) begin
            tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= ST_IDLE;
            grant_reg   <= '0;
            last_reg    <= IDX_W'(NUM_MASTERS - 1);
            tmo_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            last_reg    <= last_next;
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with two masters and a 16-cycle timeout.
module tb_wb_rr_arbiter;
    localparam int N   = 2;
    localparam int TMO = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [N-1:0]  m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
    logic [N*30-1:0] m_adr_i = '0;
    logic [N*4-1:0]  m_sel_i = '0;
    logic [N*32-1:0] m_dat_i = '0;
    logic [31:0]   m_dat_o;
    logic [N-1:0]  m_ack_o, m_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [29:0]   s_adr_o;
    logic [3:0]    s_sel_o;
    logic [31:0]   s_dat_o;
    logic [31:0]   s_dat_i = '0;
    logic          s_ack_i = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    wb_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: %0h", tag, got);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_all();
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        s_ack_i = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        m_adr_i[0*30 +: 30] = 30'h100;
        m_adr_i[1*30 +: 30] = 30'h200;
        #1;
        chk("rst s_cyc", 64'(s_cyc_o), 64'd0);
        chk("rst s_adr", 64'(s_adr_o), 64'd0);
        tick();
        tick();
        rst_ni = 1'b1;

        // 1: reset mid-transfer, then master 0 has first priority
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        tick();
        s_ack_i = 1'b1;
        #1;
        chk("t1 pre ack", 64'(m_ack_o), 64'h1);
        rst_ni = 1'b0;
        #1;
        chk("t1 rst s_cyc", 64'(s_cyc_o), 64'd0);
        chk("t1 rst ack", 64'(m_ack_o), 64'd0);
        m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        #1;
        chk("t1 idle s_cyc", 64'(s_cyc_o), 64'd0);
        tick();
        chk("t1 first grant adr", 64'(s_adr_o), 64'h100);
        idle_all();

        // 2: single master write, ack in same cycle
        m_adr_i[1*30 +: 30] = 30'h1;
        m_sel_i[1*4 +: 4]   = 4'b0011;
        m_dat_i[1*32 +: 32] = 32'hCAFEBABE;
        m_we_i = 2'b10; m_cyc_i = 2'b10; m_stb_i = 2'b10;
        #1;
        chk("t2 latency s_cyc", 64'(s_cyc_o), 64'd0);
        tick();
        s_ack_i = 1'b1;
        #1;
        chk("t2 s_adr", 64'(s_adr_o), 64'h1);
        chk("t2 s_sel", 64'(s_sel_o), 64'h3);
        chk("t2 s_dat", 64'(s_dat_o), 64'hCAFEBABE);
        chk("t2 s_we/stb", 64'({s_we_o, s_stb_o}), 64'h3);
        chk("t2 ack", 64'(m_ack_o), 64'h2);
        tick();
        m_cyc_i = 2'b00; m_stb_i = 2'b00;
        #1;
        chk("t2 ack one cycle", 64'(m_ack_o), 64'h0);
        idle_all();

        // 3: fairness with one dead IDLE cycle between grants
        m_adr_i[1*30 +: 30] = 30'h200;
        m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int g;
            g = i % 2;
            tick();
            chk($sformatf("t3 grant%0d ack", i), 64'(m_ack_o), 64'(1 << g));
            tick();
            m_cyc_i[g] = 1'b0; m_stb_i[g] = 1'b0;
            #1;
            chk($sformatf("t3 release%0d ack", i), 64'(m_ack_o), 64'h0);
            tick();
            m_cyc_i[g] = 1'b1; m_stb_i[g] = 1'b1;
            #1;
            chk($sformatf("t3 dead%0d s_cyc", i), 64'(s_cyc_o), 64'd0);
        end
        idle_all();

        // 4: burst hold of three strobes while master 1 waits
        m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t4 beat%0d ack", k), 64'(m_ack_o), 64'h1);
            if (k < 2) tick();
        end
        m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
        #1;
        chk("t4 drop s_cyc", 64'(s_cyc_o), 64'd0);
        chk("t4 drop ack", 64'(m_ack_o), 64'h0);
        tick();
        chk("t4 dead s_cyc", 64'(s_cyc_o), 64'd0);
        tick();
        chk("t4 m1 ack", 64'(m_ack_o), 64'h2);
        idle_all();

        // 5: timeout on 16th strobe cycle, then ack-wins variant
        m_cyc_i = 2'b01; m_stb_i = 2'b01; s_ack_i = 1'b0;
        tick();
        for (int k = 1; k <= TMO; k++) begin
            chk($sformatf("t5 err cyc%0d", k), 64'({m_ack_o, m_err_o}), (k == TMO) ? 64'h1 : 64'h0);
            tick();
        end
        chk("t5 err cleared", 64'(m_err_o), 64'h0);
        idle_all();
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        tick();
        for (int k = 1; k < TMO; k++) tick();
        s_ack_i = 1'b1;
        #1;
        chk("t5 ack wins ack", 64'(m_ack_o), 64'h1);
        chk("t5 ack wins err", 64'(m_err_o), 64'h0);
        idle_all();

        // 6: stray acks and read-data broadcast
        s_ack_i = 1'b1; s_dat_i = 32'h12345678;
        #1;
        chk("t6 idle ack", 64'(m_ack_o), 64'h0);
        chk("t6 dat bcast", 64'(m_dat_o), 64'h12345678);
        m_cyc_i = 2'b01; m_stb_i = 2'b00;
        tick();
        s_dat_i = 32'hA5A55A5A;
        #1;
        chk("t6 no-stb ack", 64'(m_ack_o), 64'h0);
        chk("t6 no-stb s_stb", 64'(s_stb_o), 64'h0);
        chk("t6 dat bcast2", 64'(m_dat_o), 64'hA5A55A5A);
        idle_all();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
